back_scroll_renderer: RTL and testbench

- Pixel-side consumer of the background scroll interface (BACK1X/Y, BACK2X/Y, BACK1SKIPX, BACK2SKIPX) driven by the animation clock.
- Per frame, takes a tear-free snapshot of the scroll values; per pixel, turns the screen (hCount, vCount) into a background-ROM address plus a layer-hit code.
- Sits between the VGA timing generator and the background ROM / pixel mux.

---
 rtl/back_scroll_renderer.sv | 225 ++++++++++++++++++++++
 tb/tb_back_scroll_renderer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/back_scroll_renderer.sv
// -----------------------------------------------------------------------------
// back_scroll_renderer
//
// Purpose:
//   Pixel-side consumer of the two-layer background scroll interface. Once per
//   frame it takes a tear-free snapshot of the scroll values. For each pixel it
//   converts the screen coordinate (hCount, vCount) into a background-ROM
//   address and a layer-hit code. The result appears after a fixed two-cycle
//   latency.
//
// Ports:
//   pixelClOCK              pixel clock (only clock)
//   resetN                  synchronous, active-low reset
//   frameStart              one-cycle pulse ahead of the first visible pixel
//   BACK1X/Y, BACK2X/Y      layer screen origins (animation domain, sampled)
//   BACK1SKIPX, BACK2SKIPX  first image column shown for each layer
//   hCount, vCount          current pixel coordinate
//   pixelValid              hCount/vCount are meaningful this cycle
//   BACKADDR                ROM address, row*IMG_W + col (0 when no hit)
//   BACKLAYER               0 = no hit, 1 = layer1, 2 = layer2
//   BACKVALID               pixelValid delayed by two cycles
//   staleFrame              the snapshot for this frame was not refreshed
// -----------------------------------------------------------------------------
module back_scroll_renderer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              pixelClOCK,
    input  logic              resetN,
    input  logic              frameStart,
    input  logic [9:0]        BACK1X,
    input  logic [9:0]        BACK1Y,
    input  logic [9:0]        BACK2X,
    input  logic [9:0]        BACK2Y,
    input  logic [9:0]        BACK1SKIPX,
    input  logic [9:0]        BACK2SKIPX,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              pixelValid,
    output logic [ADDR_W-1:0] BACKADDR,
    output logic [1:0]        BACKLAYER,
    output logic              BACKVALID,
    output logic              staleFrame
);

    localparam logic [10:0]       SW_L  = 11'(SCREEN_W);
    localparam logic [10:0]       SH_L  = 11'(SCREEN_H);
    localparam logic [10:0]       IW_L  = 11'(IMG_W);
    localparam logic [10:0]       IH_L  = 11'(IMG_H);
    localparam logic [ADDR_W-1:0] IW_A  = ADDR_W'(IMG_W);

    // ------------------------------------------------------------------
    // Input sampling and stability detection
    // ------------------------------------------------------------------
    logic [59:0] in_bus;
    logic [59:0] samp_q;
    // Cleared by reset so the very first cycle afterwards never counts as stable.
    logic        samp_vld_q;
    logic        stable;
    logic        capture;

    assign in_bus  = {BACK1X, BACK1Y, BACK2X, BACK2Y, BACK1SKIPX, BACK2SKIPX};
    // The value arriving this cycle must match the value captured last cycle,
    // so a change landing on the frameStart cycle itself is caught.
    assign stable  = samp_vld_q && (in_bus == samp_q);
    assign capture = frameStart && stable;

    // Unpacked views of the sample, index 0 = layer1, 1 = layer2
    logic [9:0] samp_x [2];
    logic [9:0] samp_y [2];
    logic [9:0] samp_s [2];

    assign samp_x[0] = samp_q[59:50];
    assign samp_y[0] = samp_q[49:40];
    assign samp_x[1] = samp_q[39:30];
    assign samp_y[1] = samp_q[29:20];
    assign samp_s[0] = samp_q[19:10];
    assign samp_s[1] = samp_q[9:0];

    // ------------------------------------------------------------------
    // Shadow registers and effective (this-cycle) scroll values
    // ------------------------------------------------------------------
    logic [9:0] org_x_q [2];
    logic [9:0] org_y_q [2];
    logic [9:0] skip_q  [2];
    logic [9:0] skip_fold [2];
    logic [9:0] eff_x [2];
    logic [9:0] eff_y [2];
    logic [9:0] eff_s [2];
    logic       stale_q;

    // Per-layer hit test results
    logic        hit   [2];
    logic [10:0] row_l [2];
    logic [10:0] col_l [2];

    logic [10:0] x11;
    logic [10:0] y11;
    logic        on_screen;

    assign x11       = {1'b0, hCount};
    assign y11       = {1'b0, vCount};
    assign on_screen = (x11 < SW_L) && (y11 < SH_L);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_layer
            logic [10:0] right_bound;
            logic [10:0] row_raw;
            logic [10:0] col_raw;
            logic        in_x;
            logic        row_ok;

            // A single subtraction folds oversize skip values into range.
            assign skip_fold[gi] = ({1'b0, samp_s[gi]} >= IW_L)
                                   ? 10'({1'b0, samp_s[gi]} - IW_L)
                                   : samp_s[gi];

            // A snapshot taken this very cycle is already visible to the pixel
            // presented alongside frameStart.
            assign eff_x[gi] = capture ? samp_x[gi]    : org_x_q[gi];
            assign eff_y[gi] = capture ? samp_y[gi]    : org_y_q[gi];
            assign eff_s[gi] = capture ? skip_fold[gi] : skip_q[gi];

            // Layer1 runs to the screen edge; layer2 stops where layer1 starts.
            // An empty layer falls out naturally because its range is empty.
            if (gi == 0) begin : g_right_scr
                assign right_bound = SW_L;
            end else begin : g_right_l1
                assign right_bound = {1'b0, eff_x[0]};
            end

            assign in_x    = (x11 >= {1'b0, eff_x[gi]}) && (x11 < right_bound);
            assign row_raw = y11 - {1'b0, eff_y[gi]};
            assign row_ok  = (y11 >= {1'b0, eff_y[gi]}) && (row_raw < IH_L);
            assign col_raw = x11 - {1'b0, eff_x[gi]} + {1'b0, eff_s[gi]};

            assign hit[gi]   = on_screen && in_x && row_ok;
            assign row_l[gi] = row_raw;
            assign col_l[gi] = (col_raw >= IW_L) ? (col_raw - IW_L) : col_raw;

            always_ff @(posedge pixelClOCK) begin
                if (!resetN) begin
                    org_x_q[gi] <= '0;
                    org_y_q[gi] <= '0;
                    skip_q[gi]  <= '0;
                end else if (capture) begin
                    org_x_q[gi] <= samp_x[gi];
                    org_y_q[gi] <= samp_y[gi];
                    skip_q[gi]  <= skip_fold[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: layer select
    // ------------------------------------------------------------------
    logic        s1_vld_q,   s1_vld_d;
    logic [1:0]  s1_layer_q, s1_layer_d;
    logic [10:0] s1_row_q,   s1_row_d;
    logic [10:0] s1_col_q,   s1_col_d;

    always_comb begin
        s1_vld_d   = pixelValid;
        s1_layer_d = 2'd0;
        s1_row_d   = '0;
        s1_col_d   = '0;
        if (hit[0]) begin
            s1_layer_d = 2'd1;
            s1_row_d   = row_l[0];
            s1_col_d   = col_l[0];
        end else if (hit[1]) begin
            s1_layer_d = 2'd2;
            s1_row_d   = row_l[1];
            s1_col_d   = col_l[1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: address generation
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = '0;
        if (s1_layer_q != 2'd0) begin
            addr_d = ADDR_W'(s1_row_q) * IW_A + ADDR_W'(s1_col_q);
        end
    end

    always_ff @(posedge pixelClOCK) begin
        if (!resetN) begin
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            stale_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_layer_q <= 2'd0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            BACKADDR   <= '0;
            BACKLAYER  <= 2'd0;
            BACKVALID  <= 1'b0;
        end else begin
            samp_q     <= in_bus;
            samp_vld_q <= 1'b1;
            if (frameStart) begin
                stale_q <= !stable;
            end
            s1_vld_q   <= s1_vld_d;
            s1_layer_q <= s1_layer_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            BACKADDR   <= addr_d;
            BACKLAYER  <= s1_layer_q;
            BACKVALID  <= s1_vld_q;
        end
    end

    assign staleFrame = stale_q;

endmodule

// File: tb/tb_back_scroll_renderer.sv
module tb_back_scroll_renderer;

    logic        clk;
    logic        resetN;
    logic        frameStart;
    logic [9:0]  b1x, b1y, b2x, b2y, s1, s2;
    logic [9:0]  hCount, vCount;
    logic        pixelValid;
    logic [18:0] BACKADDR;
    logic [1:0]  BACKLAYER;
    logic        BACKVALID;
    logic        staleFrame;

    int n_vec = 0;
    int n_err = 0;

    back_scroll_renderer dut (
        .pixelClOCK (clk),
        .resetN     (resetN),
        .frameStart (frameStart),
        .BACK1X     (b1x),
        .BACK1Y     (b1y),
        .BACK2X     (b2x),
        .BACK2Y     (b2y),
        .BACK1SKIPX (s1),
        .BACK2SKIPX (s2),
        .hCount     (hCount),
        .vCount     (vCount),
        .pixelValid (pixelValid),
        .BACKADDR   (BACKADDR),
        .BACKLAYER  (BACKLAYER),
        .BACKVALID  (BACKVALID),
        .staleFrame (staleFrame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [9:0]  b1x, b1y, b2x, b2y, s1, s2;
        logic [9:0]  x, y;
        logic [1:0]  lay;
        logic [18:0] addr;
    } vec_t;

    vec_t vecs [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_scroll(input logic [9:0] a1x, input logic [9:0] a1y,
                              input logic [9:0] a2x, input logic [9:0] a2y,
                              input logic [9:0] as1, input logic [9:0] as2);
        b1x = a1x; b1y = a1y; b2x = a2x; b2y = a2y; s1 = as1; s2 = as2;
    endtask

    // Let the inputs settle, then pulse frameStart.
    task automatic do_frame();
        tick(); tick(); tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    // Present one pixel; returns with its result on the outputs.
    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        hCount = x; vCount = y; pixelValid = 1'b1;
        tick();
        pixelValid = 1'b0;
        tick();
    endtask

    task automatic chk_px(input string nm, input int lay, input int addr);
        chk({nm, " valid"}, int'(BACKVALID), 1);
        chk({nm, " layer"}, int'(BACKLAYER), lay);
        chk({nm, " addr"},  int'(BACKADDR),  addr);
        $display("pixel %s x=%0d y=%0d -> layer=%0d addr=%0d", nm, hCount, vCount, BACKLAYER, BACKADDR);
    endtask

    function automatic vec_t mk(input string nm,
                                input int a1x, input int a1y, input int a2x, input int a2y,
                                input int as1, input int as2, input int x, input int y,
                                input int lay, input int addr);
        vec_t v;
        v.name = nm;
        v.b1x = 10'(a1x); v.b1y = 10'(a1y); v.b2x = 10'(a2x); v.b2y = 10'(a2y);
        v.s1 = 10'(as1); v.s2 = 10'(as2); v.x = 10'(x); v.y = 10'(y);
        v.lay = 2'(lay); v.addr = 19'(addr);
        return v;
    endfunction

    initial begin
        resetN = 1'b0; frameStart = 1'b0; pixelValid = 1'b1;
        hCount = '0; vCount = '0;
        set_scroll(0, 0, 0, 0, 0, 0);

        //  name           b1x b1y b2x b2y  s1   s2    x    y  lay addr
        vecs.push_back(mk("split_399",  400, 0,  0, 0,   0, 240, 399,  10, 2,   7039));
        vecs.push_back(mk("split_400",  400, 0,  0, 0,   0, 240, 400,  10, 1,   6400));
        vecs.push_back(mk("split_corner",400,0,  0, 0,   0, 240, 639, 479, 1, 306799));
        vecs.push_back(mk("l1_empty_r", 640, 0,  0, 0,   0,   0, 639,   0, 2,    639));
        vecs.push_back(mk("l1_empty_l", 640, 0,  0, 0,   0,   0,   0,   3, 2,   1920));
        vecs.push_back(mk("l1_full_l",    0, 0,  0, 0,   5,   0,   0,   0, 1,      5));
        vecs.push_back(mk("l1_full_wrap", 0, 0,  0, 0,   5,   0, 639,   1, 1,    644));
        vecs.push_back(mk("off_x",      400, 0,  0, 0,   0, 240, 640,   5, 0,      0));
        vecs.push_back(mk("off_y",      400, 0,  0, 0,   0, 240, 100, 480, 0,      0));
        vecs.push_back(mk("col_wrap",   640, 0,  0, 0,   0, 600,  50,   0, 2,     10));
        vecs.push_back(mk("skip_fold",  640, 0,  0, 0,   0, 700,   0,   0, 2,     60));
        vecs.push_back(mk("vert_above",   0,20,  0, 0,   0,   0, 100,  19, 0,      0));
        vecs.push_back(mk("vert_first",   0,20,  0, 0,   0,   0, 100,  20, 1,    100));
        vecs.push_back(mk("l2_left_of",  640, 0, 10, 5,  0,   0,   9,  10, 0,      0));
        vecs.push_back(mk("l2_above",    640, 0, 10, 5,  0,   0,  10,   4, 0,      0));
        vecs.push_back(mk("l2_offset",   640, 0, 10, 5,  0,   0,  20,   6, 2,    650));
        vecs.push_back(mk("l2_empty",    100, 0,100, 0,  0,   0,  50,   0, 0,      0));

        // Reset held for 3 cycles with pixelValid high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst valid", int'(BACKVALID), 0);
            chk("rst addr",  int'(BACKADDR),  0);
            chk("rst layer", int'(BACKLAYER), 0);
            chk("rst stale", int'(staleFrame), 0);
            $display("reset cycle %0d valid=%0d addr=%0d layer=%0d stale=%0d", i, BACKVALID, BACKADDR, BACKLAYER, staleFrame);
        end
        resetN = 1'b1;
        tick();
        chk("lat1 valid", int'(BACKVALID), 0);
        tick();
        chk("lat2 valid", int'(BACKVALID), 1);
        $display("post-reset latency valid=%0d", BACKVALID);
        pixelValid = 1'b0;
        tick(); tick();
        chk("idle valid", int'(BACKVALID), 0);

        // Table-driven vectors
        foreach (vecs[i]) begin
            set_scroll(vecs[i].b1x, vecs[i].b1y, vecs[i].b2x, vecs[i].b2y, vecs[i].s1, vecs[i].s2);
            do_frame();
            chk({vecs[i].name, " stale"}, int'(staleFrame), 0);
            pixel(vecs[i].x, vecs[i].y);
            chk_px(vecs[i].name, int'(vecs[i].lay), int'(vecs[i].addr));
        end

        // frameStart and pixelValid together: pixel sees the new snapshot
        set_scroll(400, 0, 0, 0, 0, 240);
        tick(); tick(); tick();
        frameStart = 1'b1; hCount = 10'd400; vCount = 10'd10; pixelValid = 1'b1;
        tick();
        frameStart = 1'b0; pixelValid = 1'b0;
        tick();
        chk_px("same_cycle", 1, 6400);

        // Tear guard
        set_scroll(300, 0, 0, 0, 0, 0);
        do_frame();
        chk("tear base stale", int'(staleFrame), 0);
        tick(); tick();
        b1x = 10'd299; frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        chk("tear stale", int'(staleFrame), 1);
        $display("tear frame stale=%0d", staleFrame);
        pixel(299, 0);
        chk_px("tear_kept", 2, 299);
        chk("tear stale held", int'(staleFrame), 1);
        do_frame();
        chk("tear recover stale", int'(staleFrame), 0);
        pixel(299, 0);
        chk_px("tear_applied", 1, 0);
        b1x = 10'd100;
        tick(); tick(); tick();
        pixel(200, 0);
        chk_px("midframe", 2, 200);
        chk("midframe stale", int'(staleFrame), 0);

        // Mid-frame reset flushes in-flight pixels and clears staleFrame
        b1x = 10'd50; frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        chk("pre-rst stale", int'(staleFrame), 1);
        hCount = 10'd10; vCount = 10'd0; pixelValid = 1'b1;
        tick();
        pixelValid = 1'b0; resetN = 1'b0;
        tick();
        chk("flush valid", int'(BACKVALID), 0);
        chk("flush stale", int'(staleFrame), 0);
        resetN = 1'b1;
        tick();
        chk("flush after valid", int'(BACKVALID), 0);
        $display("midframe reset valid=%0d stale=%0d", BACKVALID, staleFrame);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
